// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timing constants and state encoding for the SCP timers
package timer_pkg;

    localparam int MS_CYCLES_DEFAULT = 50000;
    localparam int S_CYCLES_DEFAULT  = 50000000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/ms_prescaler.sv
// rtl/ms_prescaler.sv - exact-period tick generator, one tick every CYCLES enabled clocks
module ms_prescaler
    import timer_pkg::*;
#(
    parameter int CYCLES = MS_CYCLES_DEFAULT
) (
    input  logic clk50mhz,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(CYCLES - 1);

    logic [PW-1:0] cnt;

    // Count holds while disabled so a paused timer resumes mid-period unless cleared.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk50mhz) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - ms countdown timer with sticky irq; COUNTDOWN_TIMER_AUTO_RELOAD_EN selects periodic mode
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MS_CYCLES = MS_CYCLES_DEFAULT,
    parameter int WIDTH     = 16
) (
    input  logic             clk50mhz,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             irq,
    output logic             overrun
);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] reload, reload_n, count_n;
    logic             expire, pre_clr, pre_en, tick;
    logic             irq_n, overrun_n;

    // A load or stop on the tick edge suppresses that tick entirely.
    assign pre_en = (state == ST_RUN) && !wr_en && !stop;

    ms_prescaler #(.CYCLES(MS_CYCLES)) u_prescaler (
        .clk50mhz (clk50mhz),
        .rst      (rst),
        .clr      (pre_clr),
        .en       (pre_en),
        .tick     (tick)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        expire   = 1'b0;
        pre_clr  = 1'b0;
        if (wr_en) begin
            count_n  = wr_data;
            reload_n = wr_data;
            pre_clr  = 1'b1;
            if (state == ST_RUN && wr_data == '0) begin
                state_n = ST_DONE;
                expire  = 1'b1;
            end
        end else if (stop) begin
            if (state == ST_RUN) begin
                state_n = ST_IDLE;
            end
        end else if (start && state != ST_RUN) begin
            if (count != '0) begin
                state_n = ST_RUN;
                pre_clr = 1'b1;
            end else if (state == ST_IDLE) begin
                state_n = ST_DONE;
                expire  = 1'b1;
            end
        end else if (tick) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else begin
                expire = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                count_n = reload;
                if (reload == '0) begin
                    state_n = ST_DONE;
                end
`else
                count_n = '0;
                state_n = ST_DONE;
`endif
            end
        end
    end

    // An ack coinciding with an expiry still leaves irq set for the new event.
    assign irq_n     = expire | (irq & ~irq_ack);
    assign overrun_n = ~irq_ack & (overrun | (expire & irq));

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            reload  <= '0;
            running <= 1'b0;
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            reload  <= reload_n;
            running <= (state_n == ST_RUN);
            irq     <= irq_n;
            overrun <= overrun_n;
        end
    end

endmodule
